// File: rtl/ftsd_serial_rx.sv
// Serial receiver for the four-digit display link.
// Rebuilds digit0..digit3 from a framed, oversampled one-wire stream.
module ftsd_serial_rx #(
  parameter int OVERSAMPLE = 4,
  parameter int DIGITS     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic       rxd,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int NB = 4 * DIGITS;
  localparam int TW = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [4:0]    B_LAST = 5'(NB - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t          state_q, state_n;
  logic [TW-1:0]   tick_q, tick_n;
  logic [4:0]      bit_q, bit_n;
  logic [NB-1:0]   sr_q, sr_n;
  logic [NB-1:0]   dig_q, dig_n;
  logic            valid_n, err_n;
  logic [1:0]      sync_q;
  logic            rxd_s;

  // Synchronizer runs every clk so the line is never stale on a strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rxd};
  end

  assign rxd_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      sr_q        <= '0;
      dig_q       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state_q     <= state_n;
      tick_q      <= tick_n;
      bit_q       <= bit_n;
      sr_q        <= sr_n;
      dig_q       <= dig_n;
      frame_valid <= valid_n;
      frame_err   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    tick_n  = tick_q;
    bit_n   = bit_q;
    sr_n    = sr_q;
    dig_n   = dig_q;
    valid_n = 1'b0;
    err_n   = 1'b0;
    if (sample_en) begin
      unique case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            tick_n  = '0;
            state_n = START;
          end
        end
        START: begin
          if (tick_q == T_MID) begin
            tick_n = '0;
            if (!rxd_s) begin
              bit_n   = '0;
              state_n = DATA;
            end else begin
              state_n = IDLE;
            end
          end else begin
            tick_n = tick_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_q == T_END) begin
            sr_n   = {rxd_s, sr_q[NB-1:1]};
            tick_n = '0;
            bit_n  = bit_q + 5'd1;
            if (bit_q == B_LAST) state_n = STOP;
          end else begin
            tick_n = tick_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_q == T_END) begin
            tick_n = '0;
            if (rxd_s) begin
              dig_n   = sr_q;
              valid_n = 1'b1;
              state_n = IDLE;
            end else begin
              err_n   = 1'b1;
              state_n = WAIT_HIGH;
            end
          end else begin
            tick_n = tick_q + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rxd_s) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy   = (state_q != IDLE);
  assign digit0 = dig_q[3:0];
  assign digit1 = dig_q[7:4];
  assign digit2 = dig_q[11:8];
  assign digit3 = dig_q[15:12];

endmodule

// File: tb/tb_ftsd_serial_rx.sv
// Randomized self-checking bench for ftsd_serial_rx.
// Line is driven per sample_en strobe; a frame-level model tracks digits and pulses.
module tb_ftsd_serial_rx;

  localparam int OS = 4;

  logic       clk;
  logic       rst;
  logic       sample_en;
  logic       rxd;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       frame_valid, frame_err, busy;

  int n_cmp, n_bad;
  int se_cnt, clk_cnt, div;
  int n_valid, n_err, valid_se, valid_clk;
  logic stall, prev_valid, prev_err;

  logic [15:0] exp_d;
  int exp_v, exp_e;
  int b_se, b_clk, b_se2, b_clk2, v1;

  ftsd_serial_rx #(.OVERSAMPLE(OS), .DIGITS(4)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .rxd(rxd),
    .digit0(digit0), .digit1(digit1),
    .digit2(digit2), .digit3(digit3),
    .frame_valid(frame_valid), .frame_err(frame_err),
    .busy(busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    sample_en = 0;
    div = 0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 3;
      sample_en = !stall && div == 0;
    end
  end

  initial begin
    se_cnt = 0; clk_cnt = 0;
    n_valid = 0; n_err = 0;
    prev_valid = 0; prev_err = 0;
    forever begin
      @(posedge clk);
      clk_cnt++;
      if (sample_en && !rst) se_cnt++;
      #1;
      if (frame_valid || frame_err)
        chk("excl", {31'd0, frame_valid & frame_err}, 0);
      if (frame_valid) begin
        chk("vwidth", {31'd0, prev_valid}, 0);
        n_valid++;
        valid_se  = se_cnt;
        valid_clk = clk_cnt;
      end
      if (frame_err) begin
        chk("ewidth", {31'd0, prev_err}, 0);
        n_err++;
      end
      prev_valid = frame_valid;
      prev_err   = frame_err;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_se();
    int k;
    k = 0;
    @(posedge clk);
    while (!sample_en && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (!sample_en) chk("se_wait", {31'd0, sample_en}, 1);
    #1;
  endtask

  task automatic hold(input logic b);
    rxd = b;
    repeat (OS) wait_se();
  endtask

  task automatic send_frame(input logic [15:0] data,
                            input logic stop,
                            output int bse,
                            output int bclk);
    bse  = se_cnt;
    bclk = clk_cnt;
    hold(1'b0);
    for (int i = 0; i < 16; i++) hold(data[i]);
    hold(stop);
    if (stop) begin
      exp_d = data;
      exp_v++;
    end else begin
      exp_e++;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_d0"}, {28'd0, digit0}, {28'd0, exp_d[3:0]});
    chk({tag, "_d1"}, {28'd0, digit1}, {28'd0, exp_d[7:4]});
    chk({tag, "_d2"}, {28'd0, digit2}, {28'd0, exp_d[11:8]});
    chk({tag, "_d3"}, {28'd0, digit3}, {28'd0, exp_d[15:12]});
    chk({tag, "_nv"}, n_valid, exp_v);
    chk({tag, "_ne"}, n_err, exp_e);
  endtask

  initial begin
    logic [15:0] d;
    logic        s;
    n_cmp = 0; n_bad = 0;
    exp_d = 0; exp_v = 0; exp_e = 0;
    stall = 0;
    rst = 1;
    rxd = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_fv", {31'd0, frame_valid}, 0);
    chk("rst_fe", {31'd0, frame_err}, 0);
    check_state("rst");
    rst = 0;
    repeat (3) wait_se();

    send_frame(16'h0101, 1'b1, b_se, b_clk);
    check_state("t1");
    chk("t1_lat", valid_se - b_se, 71);

    rxd = 0;
    wait_se();
    chk("gl_busy1", {31'd0, busy}, 1);
    rxd = 1;
    repeat (2) wait_se();
    chk("gl_busy0", {31'd0, busy}, 0);
    repeat (3) wait_se();
    check_state("gl");

    send_frame(16'h6789, 1'b1, b_se, b_clk);
    check_state("t3a");
    send_frame(16'h1234, 1'b0, b_se, b_clk);
    repeat (8) wait_se();
    chk("t3_busylo", {31'd0, busy}, 1);
    check_state("t3b");
    rxd = 1;
    repeat (2) wait_se();
    chk("t3_busyhi", {31'd0, busy}, 0);

    hold(1'b0);
    for (int i = 0; i < 8; i++) hold(1'b1 ^ (i % 4 >= 2));
    rst = 1;
    #1;
    exp_d = 0;
    chk("t4_busy", {31'd0, busy}, 0);
    check_state("t4r");
    repeat (2) @(posedge clk);
    rst = 0;
    rxd = 1;
    repeat (3) wait_se();
    send_frame(16'h0FA5, 1'b1, b_se, b_clk);
    check_state("t4");

    send_frame(16'h4321, 1'b1, b_se, b_clk);
    v1 = valid_se;
    send_frame(16'h1234, 1'b1, b_se2, b_clk2);
    check_state("t5");
    chk("t5_gap", valid_se - v1, OS * 18);

    repeat (2) wait_se();
    fork
      send_frame(16'hBEEF, 1'b1, b_se, b_clk);
      begin
        repeat (60) @(posedge clk);
        stall = 1;
        repeat (50) @(posedge clk);
        stall = 0;
      end
    join
    check_state("t6");
    chk("t6_lat", valid_se - b_se, 71);
    chk("t6_shift", {31'd0, (valid_clk - b_clk) > 71 * 3 + 40}, 1);

    for (int n = 0; n < 14; n++) begin
      d = 16'($urandom);
      s = ($urandom_range(3) != 0);
      send_frame(d, s, b_se, b_clk);
      if (!s) begin
        rxd = 1;
        repeat (2) wait_se();
      end else begin
        chk("rnd_lat", valid_se - b_se, 71);
      end
      check_state("rnd");
      repeat ($urandom_range(2)) wait_se();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
